// File: rtl/float_pkg.sv
// Shared definitions for the float producer/consumer blocks: field widths,
// exponent constants, IEEE-754 single field positions and the converter FSM
// state encoding.
package float_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  // Exponent of a 32-bit magnitude whose top bit is set: bias + 31
  localparam logic [EXP_W-1:0] EXP_INIT = 8'd158;
  localparam logic [EXP_W-1:0] EXP_ONE  = 8'd1;

  // Field slice positions inside a packed single-precision word
  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;
  localparam int MANT_LSB = 0;

  // Bit positions inside a normalised 32-bit magnitude (hidden one at bit 31)
  localparam int MAG_HIDDEN = 31;
  localparam int MAG_MANT_MSB = 30;
  localparam int MAG_MANT_LSB = 8;
  localparam int MAG_GUARD = 7;
  localparam int MAG_STICKY_MSB = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    OUT   = 3'd4
  } state_t;

  // Assemble a single-precision word from its three fields
  function automatic logic [31:0] pack_fields(
    input logic              sign,
    input logic [EXP_W-1:0]  exp,
    input logic [MANT_W-1:0] mant
  );
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/float_round_pack.sv
// Combinational round-to-nearest-even and pack for a normalised 32-bit
// magnitude. The caller guarantees i_mag[31] is set (or the whole word is
// don't-care) and that the exponent already reflects that normalisation.
// A mantissa carry-out bumps the exponent by one; the callers in this
// library never reach the all-ones exponent, so no overflow handling exists.
module float_round_pack
  import float_pkg::*;
(
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [31:0]      i_mag,
  output logic [31:0]      o_z
);

  logic [MANT_W-1:0] w_mant;
  logic              w_guard;
  logic              w_sticky;
  logic              w_round_up;
  logic [MANT_W:0]   w_mant_sum;
  logic [EXP_W-1:0]  w_exp_out;
  logic              w_hidden_unused;

  // The hidden one is implied by normalisation and is not stored
  assign w_hidden_unused = i_mag[MAG_HIDDEN];

  assign w_mant   = i_mag[MAG_MANT_MSB:MAG_MANT_LSB];
  assign w_guard  = i_mag[MAG_GUARD];
  assign w_sticky = |i_mag[MAG_STICKY_MSB:0];

  // Ties (guard set, nothing below) go to the even mantissa
  assign w_round_up = w_guard & (w_sticky | w_mant[0]);

  assign w_mant_sum = {1'b0, w_mant} + {{MANT_W{1'b0}}, w_round_up};

  // Carry out of the mantissa: value becomes 2^(e+1) with zero fraction
  assign w_exp_out = i_exp + {{(EXP_W-1){1'b0}}, w_mant_sum[MANT_W]};

  assign o_z = pack_fields(i_sign, w_exp_out, w_mant_sum[MANT_W-1:0]);

endmodule

// File: rtl/int_to_float.sv
// Iterative 32-bit integer to IEEE-754 single converter.
// An operand is taken in IDLE, its magnitude formed in ABS, normalised one
// bit per cycle in NORM, rounded and packed in ROUND, and held in OUT until
// the consumer takes it. Zero skips straight from ABS to OUT as +0.
// Latency from accept edge to out_valid rising: lz+3 (non-zero), 1 (zero).
module int_to_float
  import float_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_a,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_z,
  output logic        out_valid,
  input  logic        out_ready
);

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]      r_a;
  logic [31:0]      r_mag;
  logic [EXP_W-1:0] r_exp;
  logic             r_sign;
  logic [31:0]      r_z;
  logic             r_valid;

  logic             w_sign_abs;
  logic [31:0]      w_mag_abs;
  logic             w_mag_zero;
  logic [31:0]      w_z_round;
  logic             w_accept;
  logic             w_norm_done;
  logic             w_take;

  // Sign and magnitude of the captured operand; -2^31 wraps to 0x80000000,
  // which is exactly the wanted unsigned magnitude
  assign w_sign_abs  = SIGNED & r_a[31];
  assign w_mag_abs   = w_sign_abs ? (32'd0 - r_a) : r_a;
  assign w_mag_zero  = (w_mag_abs == 32'd0);
  assign w_norm_done = r_mag[MAG_HIDDEN];

  float_round_pack u_round_pack (
    .i_sign (r_sign),
    .i_exp  (r_exp),
    .i_mag  (r_mag),
    .o_z    (w_z_round)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = ABS;
      ABS:     w_state_nxt = w_mag_zero ? OUT : NORM;
      NORM:    if (w_norm_done) w_state_nxt = ROUND;
      ROUND:   w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake decode from the current state
  always_comb begin
    in_ready = 1'b0;
    w_accept = 1'b0;
    w_take   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
      end
      OUT:     w_take = out_ready;
      default: ;
    endcase
  end

  // Operand capture, normalisation datapath and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= 32'd0;
      r_mag   <= 32'd0;
      r_exp   <= '0;
      r_sign  <= 1'b0;
      r_z     <= 32'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) r_a <= in_a;
        end
        ABS: begin
          r_sign <= w_sign_abs;
          r_mag  <= w_mag_abs;
          r_exp  <= EXP_INIT;
          if (w_mag_zero) begin
            // Zero is always +0, even for a signed operand
            r_z     <= 32'd0;
            r_valid <= 1'b1;
          end
        end
        NORM: begin
          if (!w_norm_done) begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - EXP_ONE;
          end
        end
        ROUND: begin
          r_z     <= w_z_round;
          r_valid <= 1'b1;
        end
        OUT: begin
          if (w_take) r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_z     = r_z;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_int_to_float.sv
// Directed bench for int_to_float: one signed and one unsigned instance,
// hand-computed results and latencies, backpressure and mid-operation reset.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_a = 32'd0;

  logic        in_valid_s = 1'b0, out_ready_s = 1'b0;
  logic        in_ready_s, out_valid_s;
  logic [31:0] out_z_s;

  logic        in_valid_u = 1'b0, out_ready_u = 1'b0;
  logic        in_ready_u, out_valid_u;
  logic [31:0] out_z_u;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_to_float #(.SIGNED(1'b1)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_valid  (in_valid_s),
    .in_ready  (in_ready_s),
    .out_z     (out_z_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready_s)
  );

  int_to_float #(.SIGNED(1'b0)) dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_valid  (in_valid_u),
    .in_ready  (in_ready_u),
    .out_z     (out_z_u),
    .out_valid (out_valid_u),
    .out_ready (out_ready_u)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Send one operand to the selected instance, time the result, check it,
  // then take it and confirm the block returns to idle.
  task automatic send(input bit u, input logic [31:0] a, input int lat,
                      input logic [31:0] z, input bit hold_rdy, input string tag);
    int n;
    @(negedge clk);
    chk({31'd0, u ? in_ready_u : in_ready_s}, 32'd1, {tag, " in_ready"});
    in_a = a;
    if (u) in_valid_u = 1'b1; else in_valid_s = 1'b1;
    if (hold_rdy) begin
      if (u) out_ready_u = 1'b1; else out_ready_s = 1'b1;
    end
    @(negedge clk);
    in_valid_s = 1'b0;
    in_valid_u = 1'b0;
    n = 0;
    while (!(u ? out_valid_u : out_valid_s) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(32'(n), 32'(lat), {tag, " latency"});
    chk(u ? out_z_u : out_z_s, z, {tag, " out_z"});
    if (u) out_ready_u = 1'b1; else out_ready_s = 1'b1;
    @(negedge clk);
    out_ready_s = 1'b0;
    out_ready_u = 1'b0;
    chk({31'd0, u ? out_valid_u : out_valid_s}, 32'd0, {tag, " valid drop"});
    chk({31'd0, u ? in_ready_u : in_ready_s}, 32'd1, {tag, " ready back"});
  endtask

  initial begin
    int n;
    // Reset state
    #1;
    chk({31'd0, out_valid_s}, 32'd0, "reset out_valid_s");
    chk(out_z_s, 32'd0, "reset out_z_s");
    chk({31'd0, in_ready_s}, 32'd1, "reset in_ready_s");
    chk({31'd0, out_valid_u}, 32'd0, "reset out_valid_u");
    chk({31'd0, in_ready_u}, 32'd1, "reset in_ready_u");
    #13;
    rst_n = 1'b1;

    // Signed conversions
    send(1'b0, 32'h0000_0001, 34, 32'h3F80_0000, 1'b0, "s_one");
    send(1'b0, 32'hFFFF_FFFF, 34, 32'hBF80_0000, 1'b0, "s_minus_one");
    send(1'b0, 32'h0000_0000, 1,  32'h0000_0000, 1'b0, "s_zero");
    send(1'b0, 32'h8000_0000, 3,  32'hCF00_0000, 1'b0, "s_min_int");
    send(1'b0, 32'h0100_0001, 10, 32'h4B80_0000, 1'b0, "s_tie_even");
    send(1'b0, 32'h0100_0003, 10, 32'h4B80_0002, 1'b0, "s_tie_odd");
    send(1'b0, 32'h4000_0041, 4,  32'h4E80_0001, 1'b0, "s_sticky");
    send(1'b0, 32'hFFFF_FFFB, 32, 32'hC0A0_0000, 1'b1, "s_minus_five_rdy_early");

    // Unsigned conversions
    send(1'b1, 32'hFFFF_FFFF, 3,  32'h4F80_0000, 1'b0, "u_all_ones");
    send(1'b1, 32'h8000_0000, 3,  32'h4F00_0000, 1'b0, "u_top_bit");
    send(1'b1, 32'h0000_0001, 34, 32'h3F80_0000, 1'b0, "u_one");

    // Backpressure: result held for 20 cycles while new operands are offered
    @(negedge clk);
    in_a = 32'h0100_0003;
    in_valid_s = 1'b1;
    @(negedge clk);
    in_valid_s = 1'b0;
    n = 0;
    while (!out_valid_s && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(32'(n), 32'd10, "bp latency");
    in_a = 32'h1234_5678;
    in_valid_s = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk(out_z_s, 32'h4B80_0002, "bp out_z stable");
      chk({31'd0, out_valid_s}, 32'd1, "bp out_valid held");
      chk({31'd0, in_ready_s}, 32'd0, "bp in_ready low");
      @(negedge clk);
    end
    out_ready_s = 1'b1;
    @(negedge clk);
    out_ready_s = 1'b0;
    in_valid_s = 1'b0;
    chk({31'd0, out_valid_s}, 32'd0, "bp single transfer");
    chk({31'd0, in_ready_s}, 32'd1, "bp in_ready after");
    chk(out_z_s, 32'h4B80_0002, "bp out_z after");

    // Reset in the middle of normalisation
    @(negedge clk);
    in_a = 32'h0000_0001;
    in_valid_s = 1'b1;
    @(negedge clk);
    in_valid_s = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk({31'd0, out_valid_s}, 32'd0, "mid reset out_valid");
    chk(out_z_s, 32'd0, "mid reset out_z");
    chk({31'd0, in_ready_s}, 32'd1, "mid reset in_ready");
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 32'h0000_0005, 32, 32'h40A0_0000, 1'b0, "post_reset_five");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
